// File: rtl/pi_digit_serializer_if.sv
// Word-in / character-out bundle for the pi digit serializer.
// The master side feeds base-10^9 words and sinks characters; the slave
// side is the serializer itself.
interface pi_digit_serializer_if;
    logic [31:0] pi_digit;
    logic        pi_valid;
    logic        pi_done;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;

    modport master (
        output pi_digit,
        output pi_valid,
        output pi_done,
        output char_ready,
        input  char_out,
        input  char_valid
    );

    modport slave (
        input  pi_digit,
        input  pi_valid,
        input  pi_done,
        input  char_ready,
        output char_out,
        output char_valid
    );
endinterface

// File: rtl/pi_digit_serializer.sv
// Pi digit serializer: queues 32-bit base-10^9 words from the pi calculator,
// converts each to BCD by double-dabble and streams ASCII characters.
// The first word is printed without leading zeros followed by '.', later
// words as exactly nine digits, and a newline closes the stream once the
// calculator reports completion and the queue has drained.
module pi_digit_serializer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    pi_digit_serializer_if.slave        bus,
    output logic                        finished,
    output logic                        overflow,
    output logic                        range_error
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        EMIT,
        NEWLINE,
        FINISHED
    } state_t;

    state_t        state_q;
    state_t        state_d;

    // Word capture and FIFO
    logic          valid_q;
    logic          done_seen;
    logic          word_edge;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [31:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // Conversion and emission
    logic [31:0]   shifter;
    logic [39:0]   bcd;
    logic [39:0]   bcd_next;
    logic [4:0]    bit_cnt;
    logic [3:0]    dig_idx;
    logic [3:0]    cur_nib;
    logic          dot_phase;
    logic          first_word;
    logic          handshake;
    logic [7:0]    char_out_c;
    logic          char_valid_c;

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    function automatic logic [39:0] dabble_adjust(input logic [39:0] v);
        logic [39:0] r;
        r = v;
        for (int unsigned i = 0; i < 10; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Index of the most significant non-zero BCD digit (0 when all zero).
    function automatic logic [3:0] lead_index(input logic [39:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (v[i*4 +: 4] != 4'd0) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    assign word_edge  = bus.pi_valid && !valid_q;
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    // Full check uses pre-pop occupancy, so a full FIFO drops even while popping.
    assign push       = word_edge && !fifo_full;
    assign bcd_next   = {dabble_adjust(bcd)[38:0], shifter[31]};
    assign cur_nib    = bcd[{dig_idx, 2'b00} +: 4];
    assign handshake  = char_valid_c && bus.char_ready;

    assign bus.char_out   = char_out_c;
    assign bus.char_valid = char_valid_c;
    assign finished       = (state_q == FINISHED);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, FIFO pop request and character presentation.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        char_out_c   = 8'h00;
        char_valid_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = CONVERT;
                end else if (done_seen) begin
                    state_d = NEWLINE;
                end
            end
            CONVERT: begin
                if (bit_cnt == 5'd31) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                char_valid_c = 1'b1;
                char_out_c   = dot_phase ? 8'h2E : {4'h3, cur_nib};
                if (bus.char_ready) begin
                    if (dot_phase || (dig_idx == 4'd0 && !first_word)) begin
                        state_d = IDLE;
                    end
                end
            end
            NEWLINE: begin
                char_valid_c = 1'b1;
                char_out_c   = 8'h0A;
                if (bus.char_ready) begin
                    state_d = FINISHED;
                end
            end
            FINISHED: begin
                state_d = FINISHED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because occupancy guards reads.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.pi_digit;
        end
    end

    // Word capture, FIFO bookkeeping, double-dabble and digit sequencing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            done_seen   <= 1'b0;
            overflow    <= 1'b0;
            range_error <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            shifter     <= '0;
            bcd         <= '0;
            bit_cnt     <= '0;
            dig_idx     <= '0;
            dot_phase   <= 1'b0;
            first_word  <= 1'b1;
        end else begin
            valid_q <= bus.pi_valid;
            if (bus.pi_done) begin
                done_seen <= 1'b1;
            end
            if (word_edge && fifo_full) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        shifter <= fifo_mem[rd_ptr];
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONVERT: begin
                    shifter <= shifter << 1;
                    bcd     <= bcd_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    // Choose the starting digit from the final BCD value so
                    // EMIT can begin presenting on its first cycle.
                    if (bit_cnt == 5'd31) begin
                        dot_phase <= 1'b0;
                        if (first_word) begin
                            dig_idx <= lead_index(bcd_next);
                        end else begin
                            dig_idx <= 4'd8;
                            if (bcd_next[39:36] != 4'd0) begin
                                range_error <= 1'b1;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        if (dot_phase) begin
                            dot_phase  <= 1'b0;
                            first_word <= 1'b0;
                        end else if (dig_idx == 4'd0) begin
                            if (first_word) begin
                                dot_phase <= 1'b1;
                            end
                        end else begin
                            dig_idx <= dig_idx - 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pi_digit_serializer.sv
// Self-checking bench for pi_digit_serializer: directed scenarios plus
// randomized word streams compared against a string-level model.
module tb_pi_digit_serializer;

    logic clock;
    logic reset_n;
    logic finished;
    logic overflow;
    logic range_error;
    int   rdy_mode;   // 0: sink stalled, 1: always ready, 2: random
    int   checks;
    int   errors;
    byte  got[$];

    pi_digit_serializer_if bus ();

    pi_digit_serializer #(.DEPTH(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .finished    (finished),
        .overflow    (overflow),
        .range_error (range_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Sink readiness, changed just after each rising edge.
    always @(posedge clock) begin
        #1;
        bus.char_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
    end

    // Record each character that will be accepted at the next rising edge.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && bus.char_valid === 1'b1 && bus.char_ready === 1'b1) begin
            got.push_back(bus.char_out);
        end
    end

    // Expected character stream for a list of words.
    function automatic string model(input logic [31:0] w[$], input bit done);
        string s;
        s = "";
        foreach (w[i]) begin
            if (i == 0) s = $sformatf("%0d.", w[i]);
            else        s = {s, $sformatf("%09d", w[i] % 32'd1000000000)};
        end
        if (done) s = {s, "\n"};
        return s;
    endfunction

    function automatic bit model_range(input logic [31:0] w[$]);
        bit r;
        r = 1'b0;
        foreach (w[i]) if (i > 0 && w[i] >= 32'd1000000000) r = 1'b1;
        return r;
    endfunction

    function automatic string got_str();
        string s;
        s = "";
        foreach (got[i]) s = $sformatf("%s%c", s, got[i]);
        return s;
    endfunction

    function automatic string esc(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) r = {r, "\\n"};
            else               r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    task automatic do_reset();
        reset_n      = 1'b0;
        bus.pi_valid = 1'b0;
        bus.pi_done  = 1'b0;
        bus.pi_digit = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        got.delete();
    endtask

    task automatic send_word(input logic [31:0] w, input bit with_done);
        @(posedge clock);
        #1;
        bus.pi_digit = w;
        bus.pi_valid = 1'b1;
        if (with_done) bus.pi_done = 1'b1;
        @(posedge clock);
        #1;
        bus.pi_valid = 1'b0;
    endtask

    task automatic wait_chars(input int n, input int budget);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            @(negedge clock);
            c++;
        end
    endtask

    task automatic wait_finished(input int budget);
        int c;
        c = 0;
        while (finished !== 1'b1 && c < budget) begin
            @(negedge clock);
            c++;
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        string exp_s;
        reset_n      = 1'b0;
        rdy_mode     = 1;
        bus.pi_valid = 1'b0;
        bus.pi_done  = 1'b0;
        bus.pi_digit = '0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.char_out !== 8'h00) begin errors++; $display("FAIL reset_char_out: got %h required 00", bus.char_out); end
        checks++;
        if (bus.char_valid !== 1'b0) begin errors++; $display("FAIL reset_char_valid: got %b required 0", bus.char_valid); end
        checks++;
        if ({finished, overflow, range_error} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b required 000", {finished, overflow, range_error});
        end
        // pi_valid already high when reset releases must still deliver a word.
        bus.pi_digit = 32'd42;
        bus.pi_valid = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        got.delete();
        @(posedge clock);
        #1;
        bus.pi_valid = 1'b0;
        bus.pi_done  = 1'b1;
        wait_finished(500);
        exp_s = "42.\n";
        checks++;
        if (got_str() != exp_s) begin errors++; $display("FAIL valid_at_release: got \"%s\" required \"%s\"", esc(got_str()), esc(exp_s)); end
    endtask

    task automatic test_pi_stream();
        string exp_s;
        do_reset();
        rdy_mode = 1;
        send_word(32'd3, 1'b0);
        send_word(32'd141592653, 1'b0);
        send_word(32'd589793238, 1'b0);
        bus.pi_done = 1'b1;
        wait_finished(1000);
        exp_s = "3.141592653589793238\n";
        checks++;
        if (got_str() != exp_s) begin errors++; $display("FAIL pi_stream: got \"%s\" required \"%s\"", esc(got_str()), esc(exp_s)); end
        checks++;
        if ({finished, overflow, range_error} !== 3'b100) begin
            errors++; $display("FAIL pi_flags: got %b required 100", {finished, overflow, range_error});
        end
        checks++;
        if (bus.char_valid !== 1'b0) begin errors++; $display("FAIL finished_valid: got %b required 0", bus.char_valid); end
    endtask

    task automatic test_leading_zeros();
        string exp_s;
        do_reset();
        rdy_mode = 2;
        send_word(32'd3, 1'b0);
        send_word(32'd5, 1'b0);
        wait_chars(11, 500);
        repeat (60) @(negedge clock);
        exp_s = "3.000000005";
        checks++;
        if (got_str() != exp_s) begin errors++; $display("FAIL leading_kept: got \"%s\" required \"%s\"", esc(got_str()), esc(exp_s)); end
        checks++;
        if (finished !== 1'b0) begin errors++; $display("FAIL not_finished: got %b required 0", finished); end
        do_reset();
        send_word(32'd0, 1'b0);
        wait_chars(2, 300);
        repeat (60) @(negedge clock);
        exp_s = "0.";
        checks++;
        if (got_str() != exp_s) begin errors++; $display("FAIL first_zero: got \"%s\" required \"%s\"", esc(got_str()), esc(exp_s)); end
    endtask

    task automatic test_stall();
        string      exp_s;
        logic [7:0] hold_out;
        logic       hold_valid;
        do_reset();
        rdy_mode = 1;
        send_word(32'd3, 1'b0);
        send_word(32'd123456789, 1'b0);
        wait_chars(4, 500);
        rdy_mode = 0;
        @(negedge clock);
        @(negedge clock);
        hold_out   = bus.char_out;
        hold_valid = bus.char_valid;
        checks++;
        if (hold_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b required 1", hold_valid); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if ({bus.char_valid, bus.char_out} !== {hold_valid, hold_out}) begin
                errors++; $display("FAIL stall_hold cycle %0d: got %b/%h required %b/%h", i, bus.char_valid, bus.char_out, hold_valid, hold_out);
            end
        end
        rdy_mode = 1;
        wait_chars(11, 500);
        repeat (10) @(negedge clock);
        exp_s = "3.123456789";
        checks++;
        if (got_str() != exp_s) begin errors++; $display("FAIL stall_stream: got \"%s\" required \"%s\"", esc(got_str()), esc(exp_s)); end
    endtask

    task automatic test_overflow();
        logic [31:0] w[$];
        string       exp_s;
        do_reset();
        rdy_mode = 0;
        w.delete();
        for (int i = 0; i < 6; i++) begin
            w.push_back($urandom_range(0, 999999999));
            send_word(w[i], 1'b0);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b required 1", overflow); end
        w.pop_back();
        rdy_mode    = 2;
        bus.pi_done = 1'b1;
        wait_finished(3000);
        exp_s = model(w, 1'b1);
        checks++;
        if (got_str() != exp_s) begin errors++; $display("FAIL overflow_stream: got \"%s\" required \"%s\"", esc(got_str()), esc(exp_s)); end
        checks++;
        if ({finished, overflow, range_error} !== 3'b110) begin
            errors++; $display("FAIL overflow_flags: got %b required 110", {finished, overflow, range_error});
        end
    endtask

    task automatic test_range();
        string exp_s;
        do_reset();
        rdy_mode = 1;
        send_word(32'd3, 1'b0);
        send_word(32'd1000000000, 1'b0);
        wait_chars(11, 500);
        repeat (10) @(negedge clock);
        exp_s = "3.000000000";
        checks++;
        if (got_str() != exp_s) begin errors++; $display("FAIL range_stream: got \"%s\" required \"%s\"", esc(got_str()), esc(exp_s)); end
        checks++;
        if (range_error !== 1'b1) begin errors++; $display("FAIL range_flag: got %b required 1", range_error); end
    endtask

    task automatic test_done_only();
        do_reset();
        rdy_mode = 2;
        @(posedge clock);
        #1;
        bus.pi_done = 1'b1;
        wait_finished(300);
        checks++;
        if (got_str() != "\n") begin errors++; $display("FAIL done_only: got \"%s\" required \"\\n\"", esc(got_str())); end
        checks++;
        if (finished !== 1'b1) begin errors++; $display("FAIL done_finished: got %b required 1", finished); end
    endtask

    task automatic test_reset_mid_word();
        string exp_s;
        do_reset();
        rdy_mode = 1;
        send_word(32'd3, 1'b0);
        send_word(32'd123456789, 1'b0);
        wait_chars(4, 500);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.char_valid, bus.char_out} !== {1'b0, 8'h00}) begin
            errors++; $display("FAIL mid_reset_outputs: got %b/%h required 0/00", bus.char_valid, bus.char_out);
        end
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        got.delete();
        send_word(32'd7, 1'b1);
        wait_finished(500);
        exp_s = "7.\n";
        checks++;
        if (got_str() != exp_s) begin errors++; $display("FAIL after_mid_reset: got \"%s\" required \"%s\"", esc(got_str()), esc(exp_s)); end
    endtask

    task automatic test_random_streams();
        logic [31:0] w[$];
        string       exp_s;
        int          n;
        bit          done_with_last;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            rdy_mode = 2;
            w.delete();
            n = $urandom_range(1, 5);
            done_with_last = $urandom_range(0, 1) == 1;
            for (int i = 0; i < n; i++) begin
                if (i == 0 || $urandom_range(0, 3) == 0) w.push_back($urandom);
                else                                     w.push_back($urandom_range(0, 999999999));
                send_word(w[i], done_with_last && (i == n - 1));
            end
            bus.pi_done = 1'b1;
            wait_finished(3000);
            exp_s = model(w, 1'b1);
            checks++;
            if (got_str() != exp_s) begin errors++; $display("FAIL random_stream %0d: got \"%s\" required \"%s\"", r, esc(got_str()), esc(exp_s)); end
            checks++;
            if ({finished, overflow, range_error} !== {1'b1, 1'b0, model_range(w)}) begin
                errors++; $display("FAIL random_flags %0d: got %b required %b", r, {finished, overflow, range_error}, {1'b1, 1'b0, model_range(w)});
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rdy_mode = 1;
        test_reset();
        test_pi_stream();
        test_leading_zeros();
        test_stall();
        test_overflow();
        test_range();
        test_done_only();
        test_reset_mid_word();
        test_random_streams();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
